// File: rtl/regfile_sb_if.sv
// Register-file bus: two combinational read ports, one write port, a reserve port and the clear handshake.
interface regfile_sb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_rdy1;
  logic              rd_rdy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  rd_data1, rd_data2, rd_rdy1, rd_rdy2, clr_busy, clr_done
  );
  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output rd_data1, rd_data2, rd_rdy1, rd_rdy2, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised 2R1W register file with per-register pending bits, write bypass
// and a one-register-per-cycle clear sweep.
module regfile_sb_cell #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              rsv,
  input  logic              clr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] q,
  output logic              pend
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q    <= '0;
      pend <= 1'b0;
    end else begin
      if (clr)     q <= '0;
      else if (we) q <= wd;
      // a reserve landing with its own write leaves the register pending
      if (clr)      pend <= 1'b0;
      else if (rsv) pend <= 1'b1;
      else if (we)  pend <= 1'b0;
    end
endmodule

module regfile_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int HAS_ZERO = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS   = 1
) (
  input logic       clk,
  input logic       reset,
  regfile_sb_if.slave bus
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TBL_N = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              rdy;
  } rd_rsp_t;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             idle, sweep, wr_ok, rsv_ok;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             pend;
  logic [TBL_N-1:0][DATA_W-1:0]    regs_tbl;
  logic [TBL_N-1:0]                pend_tbl;

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    if (NUM_REGS >= TBL_N) return 1'b1;
    return a < ADDR_W'(NUM_REGS);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (HAS_ZERO != 0) && (a == ADDR_W'(ZERO_IDX));
  endfunction

  assign idle   = (state == S_IDLE);
  assign sweep  = (state == S_SWEEP);
  assign wr_ok  = idle && bus.wr_en  && in_rng(bus.wr_addr)  && !is_zero(bus.wr_addr);
  assign rsv_ok = idle && bus.rsv_en && in_rng(bus.rsv_addr) && !is_zero(bus.rsv_addr);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (bus.clr_req) begin
                   state <= S_SWEEP;
                   idx   <= '0;
                 end
        S_SWEEP: if (idx == IDX_W'(NUM_REGS - 1)) state <= S_DONE;
                 else                             idx   <= idx + 1'b1;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    regfile_sb_cell #(.DATA_W(DATA_W)) u_cell (
      .clk  (clk),
      .reset(reset),
      .we   (wr_ok  && (bus.wr_addr  == ADDR_W'(r))),
      .rsv  (rsv_ok && (bus.rsv_addr == ADDR_W'(r))),
      .clr  (sweep  && (idx == IDX_W'(r))),
      .wd   (bus.wr_data),
      .q    (regs[r]),
      .pend (pend[r])
    );
  end

  // pad to the full address space so any address indexes a defined entry
  always_comb begin
    regs_tbl                 = '0;
    pend_tbl                 = '0;
    regs_tbl[NUM_REGS-1:0]   = regs;
    pend_tbl[NUM_REGS-1:0]   = pend;
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    rd_rsp_t           rsp;
    assign ra = (p == 0) ? bus.rd_addr1 : bus.rd_addr2;
    always_comb begin
      rsp = '{data: regs_tbl[ra], rdy: !pend_tbl[ra]};
      if (!in_rng(ra) || is_zero(ra))
        rsp = '{data: '0, rdy: 1'b1};
      else if ((BYPASS != 0) && wr_ok && (bus.wr_addr == ra))
        rsp = '{data: bus.wr_data, rdy: 1'b1};
    end
  end

  assign bus.rd_data1 = g_rd[0].rsp.data;
  assign bus.rd_rdy1  = g_rd[0].rsp.rdy;
  assign bus.rd_data2 = g_rd[1].rsp.data;
  assign bus.rd_rdy2  = g_rd[1].rsp.rdy;
  assign bus.clr_busy = sweep;
  assign bus.clr_done = (state == S_DONE);
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 32x64 two-read/one-write register file.
- Adds configurable width and depth, optional hardwired-zero register, and write-to-read bypass.
- Adds a per-register pending (scoreboard) bit for long-latency producers and a sequenced clear engine with a busy/done handshake.
- Sits in the CPU decode stage; read ports feed the operand muxes, the write port is driven from writeback.

Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of implemented registers; must satisfy 1 <= NUM_REGS <= 2^ADDR_W.
- HAS_ZERO, 1, when 1, register ZERO_IDX always reads 0 and ignores writes and reservations.
- ZERO_IDX, 31, index of the hardwired-zero register; must be < NUM_REGS when HAS_ZERO=1.
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_data2  out  DATA_W  read port 2 data, combinational.
- rd_rdy1  out  1  read port 1 operand valid (not pending).
- rd_rdy2  out  1  read port 2 operand valid (not pending).
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve request: mark rsv_addr pending.
- rsv_addr  in  ADDR_W  register to reserve.
- clr_req  in  1  request to clear all registers.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0 and all pending bits cleared.
  - FSM forced to IDLE; clr_busy=0, clr_done=0.
  - Applies immediately, including mid-sweep. On release, state is IDLE with everything zero.
- Storage: registers 0..NUM_REGS-1, each DATA_W flops.
- Valid write: wr_en=1, wr_addr<NUM_REGS, not the zero register, FSM=IDLE.
  - Updates the register at the clock edge and clears its pending bit.
- Reads (combinational):
  - Out-of-range address (>=NUM_REGS) returns 0 with rdy=1.
  - Zero register returns 0 with rdy=1.
  - Bypass: when BYPASS=1, FSM=IDLE and a valid write targets the read address, rd_data=wr_data and rdy=1.
  - Otherwise rd_data is the stored value and rdy = not pending.
- Reserve: rsv_en=1, rsv_addr in range, not the zero register, FSM=IDLE.
  - Sets the pending bit at the clock edge.
  - Reserve and valid write to the same register in the same cycle: data is written AND the pending bit ends set (reserve wins).
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 loads idx=0 and moves to SWEEP.
  - SWEEP:
    - clr_busy=1.
    - Each cycle writes 0 to register idx, clears pend[idx], then increments idx.
    - When idx==NUM_REGS-1 is cleared, move to DONE.
    - Lasts exactly NUM_REGS cycles.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then return to IDLE.
  - Latency: clr_req sampled at edge k gives clr_busy high for cycles k+1..k+NUM_REGS and clr_done high in cycle k+NUM_REGS+1.
  - During SWEEP and DONE: wr_en, rsv_en and clr_req are ignored (dropped, not queued), and bypass is disabled.
  - Reads during SWEEP return current contents and pending state; already-swept registers read 0 with rdy=1.
- idx counter width: ceil(log2(NUM_REGS)), minimum 1; no wrap beyond NUM_REGS-1.
- All outputs: no X after reset for any in-range or out-of-range address.

Test Plan:
- Reset, then write 0xDEADBEEF_CAFEF00D to r5; read r5 next cycle on both ports -> that value, rdy=1. Read r31 -> 0. Write r31 with 0x1, read r31 -> 0.
- Same-cycle write r7=0x1234 while rd_addr1=7, BYPASS=1 -> rd_data1=0x1234 that cycle. With BYPASS=0 -> old value (0).
- rsv_en r3 -> rd_rdy1(r3)=0 next cycle. Write r3=0x55 -> rdy=1 during the write cycle (bypass) and stays 1 after. Simultaneous rsv r4 + write r4=0x9 -> r4 reads 0x9, rdy=0.
- Fill r0..r30 with nonzero values, pend r2, pulse clr_req -> clr_busy high exactly 32 cycles, clr_done pulse in cycle 33. All registers read 0, all rdy=1. A wr_en to r10 mid-sweep is dropped.
- Assert reset low at sweep cycle 10 -> clr_busy drops immediately. After release: FSM IDLE, all registers 0, no clr_done pulse.
- NUM_REGS=16, DATA_W=32, HAS_ZERO=0: write r0=0xA -> reads 0xA. Read address 20 -> 0, rdy=1. Write to address 20 has no effect. Sweep takes 16 cycles.
